// File: rtl/spi_2_master.sv
// SPI master that frames a control word {write, size, addr} followed by 8/16/32
// data bits, with programmable sck half-period and per-transfer {cpol,cpha}.
module spi_2_master #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 32,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              write,
  input  logic [1:0]        size,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DWIDTH-1:0] rdata,
  output logic              sck,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso,
  output logic [2:0]        dbg_state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_CTRL  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam int FW  = AWIDTH + 3 + DWIDTH;
  localparam int BCW = ($clog2(AWIDTH + 3) > 6) ? $clog2(AWIDTH + 3) : 6;
  localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);

  logic [2:0]        state_q, state_d;
  logic [DVW-1:0]    div_q, div_d;
  logic              phase_q, phase_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]    nbits_q, nbits_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              write_q, write_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [DWIDTH-1:0] rx_q, rx_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              sck_q, sck_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              tick, do_pop, do_smp, last_bit;
  logic [DWIDTH-1:0] wdata_al;
  logic [BCW-1:0]    nbits_sel;

  // Write data is left-aligned so that the first data bit follows addr[0] in one shift register.
  always_comb begin
    wdata_al  = '0;
    nbits_sel = BCW'(8);
    case (size)
      2'b00: begin wdata_al = wdata << (DWIDTH - 8);  nbits_sel = BCW'(8);  end
      2'b01: begin wdata_al = wdata << (DWIDTH - 16); nbits_sel = BCW'(16); end
      2'b10: begin wdata_al = wdata << (DWIDTH - 32); nbits_sel = BCW'(32); end
      default: begin wdata_al = '0; nbits_sel = BCW'(8); end
    endcase
    if (!write) wdata_al = '0;
  end

  assign tick     = (div_q == DIV_LAST);
  assign last_bit = (state_q == S_CTRL) ? (bit_cnt_q == BCW'(AWIDTH + 2))
                                        : (bit_cnt_q == nbits_q - BCW'(1));

  // start is a one-cycle request honoured only in IDLE; done pulses once per accepted
  // request (err with it for size 11), busy covers every non-IDLE cycle.
  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + DVW'(1);
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    nbits_d   = nbits_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    write_d   = write_q;
    frame_d   = frame_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    sck_d     = sck_q;
    ss_n_d    = ss_n_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    do_pop    = 1'b0;
    do_smp    = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (start) begin
          if (size == 2'b11) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d   = S_SETUP;
            ss_n_d    = 1'b0;
            cpol_d    = mode[1];
            cpha_d    = mode[0];
            sck_d     = mode[1];
            write_d   = write;
            nbits_d   = nbits_sel;
            frame_d   = {write, size, addr, wdata_al};
            rx_d      = '0;
            mosi_d    = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
          end
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d   = S_CTRL;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
          do_pop    = !cpha_q;
        end
      end
      S_CTRL, S_DATA: begin
        if (tick) begin
          if (!phase_q) begin
            sck_d   = ~cpol_q;
            phase_d = 1'b1;
            do_pop  = cpha_q;
            do_smp  = !cpha_q && (state_q == S_DATA) && !write_q;
          end else begin
            sck_d   = cpol_q;
            phase_d = 1'b0;
            do_smp  = cpha_q && (state_q == S_DATA) && !write_q;
            if (last_bit) begin
              bit_cnt_d = '0;
              if (state_q == S_CTRL) begin
                state_d = S_DATA;
                do_pop  = !cpha_q;
              end else begin
                state_d = S_HOLD;
                if (!cpha_q) mosi_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
              do_pop    = !cpha_q;
            end
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d = S_IDLE;
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          if (!write_q) rdata_d = rx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_pop) begin
      mosi_d  = frame_q[FW-1];
      frame_d = {frame_q[FW-2:0], 1'b0};
    end
    if (do_smp) rx_d = {rx_q[DWIDTH-2:0], miso};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      nbits_q   <= BCW'(8);
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      write_q   <= 1'b0;
      frame_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      sck_q     <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      nbits_q   <= nbits_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      write_q   <= write_d;
      frame_q   <= frame_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      sck_q     <= sck_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign sck         = sck_q;
  assign ss_n        = ss_n_q;
  assign mosi        = mosi_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_2_master.sv
// Bench for spi_2_master: a bit-level slave monitor rebuilds each frame from sck/mosi
// and serves miso, and every frame is compared with a model built from the frame rules.
module tb_spi_2_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CD = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          write = 1'b0;
  logic [1:0]    size  = 2'b00;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    mode  = 2'b00;
  logic          miso  = 1'bz;
  logic          busy, done, err, sck, ss_n, mosi;
  logic [DW-1:0] rdata;
  logic [2:0]    dbg_state;

  spi_2_master #(.AWIDTH(AW), .DWIDTH(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write(write), .size(size),
    .addr(addr), .wdata(wdata), .mode(mode), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .dbg_state_o(dbg_state)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // slave model state, set by the driver before each frame
  logic        m_cpol = 1'b0, m_cpha = 1'b0, m_read = 1'b0;
  logic [31:0] m_slave = '0;
  int          m_n = 8;
  logic        prev_sck = 1'b0, prev_ss_n = 1'b1, prev_mosi = 1'b0;
  int          lcnt = 0, tcnt = 0, bad_edge = 0, idle_chg = 0;
  logic        mosi_bits[$];

  logic [DW-1:0] exp_rdata = '0;
  logic          last_cpol = 1'b0;

  always @(negedge clk) begin
    int idx;
    if (!rst_n) begin
      miso = 1'bz;
    end else if (prev_ss_n && !ss_n) begin
      lcnt = 0; tcnt = 0; bad_edge = 0;
      mosi_bits.delete();
    end else if (!prev_ss_n && !ss_n) begin
      if (sck != prev_sck) begin
        if (sck != m_cpol) begin
          lcnt++;
          if (!m_cpha) mosi_bits.push_back(mosi);
        end else begin
          tcnt++;
          if (m_cpha) mosi_bits.push_back(mosi);
        end
      end
      if (mosi != prev_mosi) begin
        if (m_cpha) begin
          if (!(sck != prev_sck && sck != m_cpol)) bad_edge++;
        end else begin
          if (!((sck != prev_sck && sck == m_cpol) || lcnt == 0)) bad_edge++;
        end
      end
      idx = m_cpha ? (lcnt - 1 - (AW + 3)) : (tcnt - (AW + 3));
      if (m_read && idx >= 0 && idx < m_n) miso = m_slave[m_n - 1 - idx];
      else miso = 1'bz;
    end else if (prev_ss_n && ss_n && sck != prev_sck) begin
      idle_chg++;
    end
    prev_sck  = sck;
    prev_ss_n = ss_n;
    prev_mosi = mosi;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one legal frame and checks it; chain=1 returns in the done cycle.
  task automatic do_frame(input logic wr, input logic [1:0] sz, input logic [7:0] ad,
                          input logic [31:0] wd, input logic [1:0] md, input logic [31:0] sw,
                          input bit poke, input bit chain, input string tag);
    int n, nb, k;
    logic [63:0] got, expv, mask;
    logic [0:0] exp_q[$];
    n  = 8 << sz;
    nb = AW + 3 + n;
    exp_q.delete();
    exp_q.push_back(wr);
    exp_q.push_back(sz[1]);
    exp_q.push_back(sz[0]);
    for (int i = AW - 1; i >= 0; i--) exp_q.push_back(ad[i]);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(wr ? wd[i] : 1'b0);
    m_cpol = md[1]; m_cpha = md[0]; m_read = !wr; m_slave = sw; m_n = n;

    chk({tag, " ss_n_before"}, 64'(ss_n), 64'd1);
    write = wr; size = sz; addr = ad; wdata = wd; mode = md; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    write = 1'($urandom); addr = AW'($urandom); wdata = $urandom; mode = 2'($urandom);
    k = 0;
    while (1) begin
      @(negedge clk);
      if (k == 0) begin
        chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        chk({tag, " ss_n_after_accept"}, 64'(ss_n), 64'd0);
      end
      if (poke && k == 20) begin
        start = 1'b1; write = ~wr; size = 2'b11; mode = ~md;
      end
      if (poke && k == 21) start = 1'b0;
      if (done === 1'b1 || k >= 5000) break;
      k++;
    end
    #1;
    chk({tag, " done_cycle"}, 64'(k + 1), 64'(1 + CD * (2 * nb + 2)));
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " ss_n_at_done"}, 64'(ss_n), 64'd1);
    chk({tag, " sck_idle"}, 64'(sck), 64'(md[1]));
    chk({tag, " leading_edges"}, 64'(lcnt), 64'(nb));
    chk({tag, " trailing_edges"}, 64'(tcnt), 64'(nb));
    chk({tag, " mosi_edge_discipline"}, 64'(bad_edge), 64'd0);
    chk({tag, " bit_count"}, 64'(mosi_bits.size()), 64'(exp_q.size()));
    got = '0; expv = '0;
    for (int i = 0; i < mosi_bits.size() && i < 64; i++) got = {got[62:0], mosi_bits[i]};
    for (int i = 0; i < exp_q.size() && i < 64; i++) expv = {expv[62:0], exp_q[i]};
    chk({tag, " mosi_bits"}, got, expv);
    if (!wr) begin
      mask = (n == 32) ? 64'hFFFF_FFFF : ((64'd1 << n) - 64'd1);
      exp_rdata = sw & mask[DW-1:0];
    end
    chk({tag, " rdata"}, 64'(rdata), 64'(exp_rdata));
    last_cpol = md[1];
    if (!chain) begin
      @(negedge clk);
      chk({tag, " done_pulse_end"}, 64'(done), 64'd0);
    end
  endtask

  task automatic do_illegal(input logic [1:0] md);
    int chg0;
    chg0 = idle_chg;
    chk("illegal ss_n_before", 64'(ss_n), 64'd1);
    size = 2'b11; mode = md; write = 1'($urandom); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("illegal done", 64'(done), 64'd1);
    chk("illegal err", 64'(err), 64'd1);
    chk("illegal ss_n", 64'(ss_n), 64'd1);
    chk("illegal busy", 64'(busy), 64'd0);
    chk("illegal sck_kept", 64'(sck), 64'(last_cpol));
    repeat (4) @(negedge clk);
    chk("illegal done_end", 64'(done), 64'd0);
    chk("illegal sck_edges", 64'(idle_chg), 64'(chg0));
    size = 2'b00;
  endtask

  logic        r_wr, done_seen;
  logic [1:0]  r_sz, r_md;
  logic [7:0]  r_ad;
  logic [31:0] r_wd, r_sw;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset sck", 64'(sck), 64'd0);
    chk("reset ss_n", 64'(ss_n), 64'd1);
    chk("reset mosi", 64'(mosi), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;

    do_frame(1'b1, 2'b00, 8'h05, 32'h0000_00A5, 2'b00, 32'h0, 1'b0, 1'b0, "wr8");
    do_frame(1'b0, 2'b10, 8'h04, 32'h0, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0, "rd32");
    do_frame(1'b0, 2'b00, 8'h11, 32'h0, 2'b00, 32'h0000_003C, 1'b0, 1'b0, "rd8");
    do_frame(1'b1, 2'b01, 8'h2A, 32'hFFFF_1234, 2'b11, 32'h0, 1'b0, 1'b0, "wr16_m11");
    do_illegal(2'b01);
    do_frame(1'b0, 2'b01, 8'h80, 32'h0, 2'b10, 32'h0000_C3A5, 1'b1, 1'b0, "rd16_poke");
    do_frame(1'b1, 2'b10, 8'hF0, 32'h8765_4321, 2'b01, 32'h0, 1'b0, 1'b1, "chain_a");
    do_frame(1'b0, 2'b00, 8'h0F, 32'h0, 2'b11, 32'h0000_0096, 1'b0, 1'b0, "chain_b");

    for (int i = 0; i < 6; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 2));
      r_md = 2'($urandom_range(0, 3));
      r_ad = 8'($urandom);
      r_wd = $urandom;
      r_sw = $urandom;
      do_frame(r_wr, r_sz, r_ad, r_wd, r_md, r_sw, 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    // abort a frame around bit 10 of its control/data stream
    m_cpol = 1'b0; m_cpha = 1'b0; m_read = 1'b1; m_slave = 32'h5A5A_5A5A; m_n = 32;
    write = 1'b0; size = 2'b10; addr = 8'h33; mode = 2'b00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (CD + 2 * CD * 10 + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    last_cpol = 1'b0;
    chk("abort ss_n", 64'(ss_n), 64'd1);
    chk("abort sck", 64'(sck), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort mosi", 64'(mosi), 64'd0);
    chk("abort rdata", 64'(rdata), 64'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    rst_n = 1'b1;
    do_frame(1'b1, 2'b01, 8'h5C, 32'h0000_BEEF, 2'b00, 32'h0, 1'b0, 1'b1, "after_abort");
    chk("abort no_done", 64'(done_seen), 64'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_2_master.md
SPI_2_MASTER -- requirements
Module: spi_2_master

Interface
REQ-001 Parameter AWIDTH, default 8, is the address width in bits; it SHALL match the attached slave.
REQ-002 Parameter DWIDTH, default 32, is the maximum data width in bits.
REQ-003 Parameter CLK_DIV, default 2, minimum 1, is the sck half-period in clk cycles.
REQ-004 clk  in  1  system clock; all internal state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request; it is accepted only in IDLE.
REQ-007 write  in  1  1 selects a write transfer, 0 selects a read transfer; sampled at accept.
REQ-008 size  in  2  transfer size: 00 is 8 bits, 01 is 16 bits, 10 is 32 bits, 11 is illegal; sampled at accept.
REQ-009 addr  in  AWIDTH  byte address; sampled at accept.
REQ-010 wdata  in  DWIDTH  write data, right-aligned; sampled at accept.
REQ-011 mode  in  2  {cpol,cpha}; sampled at accept.
REQ-012 busy  out  1  high from the cycle after accept until done.
REQ-013 done  out  1  one-cycle pulse that ends every accepted request.
REQ-014 err  out  1  valid with done; high only for size 11.
REQ-015 rdata  out  DWIDTH  read result, zero-extended and right-aligned; it holds until the next read completes.
REQ-016 sck  out  1  SPI clock; it idles at the latched cpol.
REQ-017 ss_n  out  1  active-low slave select.
REQ-018 mosi  out  1  serial data to the slave.
REQ-019 miso  in  1  serial data from the slave; it may be high-Z outside the read data phase.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, CTRL, DATA and HOLD.
REQ-021 IDLE -> SETUP on start with a legal size; start with size 11 stays in IDLE and gives done=1 with err=1 on the next cycle; sck and ss_n are untouched.
REQ-022 SETUP: ss_n goes low on the cycle after accept and the state lasts CLK_DIV clk cycles with no sck edge.
REQ-023 CTRL: AWIDTH+3 bits, sent MSB first: write, size[1], size[0], addr[AWIDTH-1]..addr[0].
REQ-024 DATA: N bits (8, 16 or 32); a write sends wdata[N-1]..wdata[0] on mosi; a read drives mosi=0 and samples miso.
REQ-025 Each bit lasts 2*CLK_DIV clk cycles: a leading sck edge, then a trailing sck edge CLK_DIV cycles later.
REQ-026 cpha=0: mosi is valid CLK_DIV cycles before the leading edge, changes on the trailing edge, and miso is sampled on the leading edge.
REQ-027 cpha=1: mosi changes on the leading edge and miso is sampled on the trailing edge.
REQ-028 The total frame SHALL contain exactly AWIDTH+3+N sck pulses, and sck returns to cpol after the last trailing edge.
REQ-029 HOLD: lasts CLK_DIV cycles after the last edge; ss_n then goes high, and done pulses in that same cycle.
REQ-030 Latency: with start accepted at cycle 0, done occurs at cycle 1 + CLK_DIV*(2*(AWIDTH+3+N)+2).
REQ-031 The sampled read bits shift into a DWIDTH register MSB first; rdata updates only at done and only for a read.
REQ-032 start while busy SHALL be ignored and SHALL have no effect on the frame in progress.
REQ-033 start in the cycle done is high SHALL be accepted, since the state is IDLE; ss_n then stays high for at least one clk cycle between frames.
REQ-034 The divider counter and the bit counter SHALL reset at each state entry; the bit counter SHALL be at least 6 bits wide.

Reset
REQ-035 While rst_n=0: state=IDLE, sck=0, ss_n=1, mosi=0, busy=0, done=0, err=0, rdata=0, and the latched mode is 00.
REQ-036 Reset asserted mid-frame SHALL force ss_n=1 immediately (asynchronously) and abort the frame without a done pulse.
REQ-037 After rst_n is released, the block SHALL accept start on the first clk edge.

Verification
REQ-038 AWIDTH=8, CLK_DIV=2, mode 00: write size 00 to addr 0x05 with wdata 0xA5 -> mosi bits 1,00,00000101,10100101; 19 sck pulses; done at cycle 81; err=0.
REQ-039 Read size 10 from addr 0x04 with the slave model returning 0xDEADBEEF -> rdata=0xDEADBEEF at done; 43 sck pulses.
REQ-040 Read size 00 with miso bits 0x3C -> rdata=0x0000003C; the upper bits are zero.
REQ-041 Mode 11, 16-bit write of 0x1234 -> sck idles high, mosi changes on falling (leading) edges, and the slave reconstructs 0x1234.
REQ-042 size 11 -> done=1 and err=1 one cycle after start; ss_n stays 1 and sck shows no edges.
REQ-043 rst_n pulsed low at bit 10 of a frame -> ss_n=1 immediately, no done pulse, and a following frame completes correctly.
